// File: rtl/shiftreg_rw_engine_if.sv
// Host-side handshake bundle for shiftreg_rw_engine: start/write word in,
// busy/done/readback word out.
interface shiftreg_rw_engine_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output start,
        output wr_data,
        input  busy,
        input  done,
        input  rd_data
    );

    modport slave (
        input  start,
        input  wr_data,
        output busy,
        output done,
        output rd_data
    );
endinterface

// File: rtl/shiftreg_rw_engine.sv
// Serial shift-register write/readback engine: turns the synchronized divider clock
// into a gated sr_clk, MSB-first sr_din and an sr_load strobe, capturing sr_dout.
module shiftreg_rw_engine #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      sclk_in,
    shiftreg_rw_engine_if.slave       bus,
    output logic                      sr_clk,
    output logic                      sr_din,
    output logic                      sr_load,
    input  logic                      sr_dout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LOAD  = 2'd3;

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_shreg;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sr_clk;
    logic                 r_sr_din;
    logic                 r_sr_load;
    logic [WIDTH-1:0]     r_rd_data;

    logic                 w_rise;
    logic                 w_fall;

    // sclk_in is asynchronous to clk_in: two flops to synchronize, a third to detect edges.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sclk_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sr_clk  <= 1'b0;
            r_sr_din  <= 1'b0;
            r_sr_load <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shreg <= bus.wr_data;
                        r_cnt   <= CNT_WIDTH'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= ST_ARM;
                    end
                end
                // Wait for a fall so the first data bit gets a full half period of setup.
                ST_ARM: begin
                    if (w_fall) begin
                        r_sr_din <= r_shreg[WIDTH-1];
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_sr_clk <= 1'b1;
                        r_shreg  <= {r_shreg[WIDTH-2:0], sr_dout};
                        r_cnt    <= r_cnt - CNT_WIDTH'(1);
                    end else if (w_fall) begin
                        r_sr_clk <= 1'b0;
                        if (r_cnt != '0) begin
                            r_sr_din <= r_shreg[WIDTH-1];
                        end else begin
                            r_sr_din  <= 1'b0;
                            r_sr_load <= 1'b1;
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_fall) begin
                        r_sr_load <= 1'b0;
                        r_rd_data <= r_shreg;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rd_data = r_rd_data;
    assign sr_clk      = r_sr_clk;
    assign sr_din      = r_sr_din;
    assign sr_load     = r_sr_load;

endmodule

// File: tb/tb_shiftreg_rw_engine.sv
// Scoreboard bench for shiftreg_rw_engine (WIDTH=8): expected readback words are queued
// at issue time and checked by a monitor whenever done pulses.
module tb_shiftreg_rw_engine;

    localparam int WIDTH = 8;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic sclk_in;
    logic sr_clk, sr_din, sr_load, sr_dout;

    shiftreg_rw_engine_if #(.WIDTH(WIDTH)) bus ();

    shiftreg_rw_engine #(.WIDTH(WIDTH)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .sclk_in (sclk_in),
        .bus     (bus),
        .sr_clk  (sr_clk),
        .sr_din  (sr_din),
        .sr_load (sr_load),
        .sr_dout (sr_dout)
    );

    always #5 clk_in = ~clk_in;

    int compareCount = 0;
    int failCount    = 0;
    int riseCount    = 0;
    int loadCycles   = 0;
    int doneCount    = 0;
    logic [7:0] dinLog = '0;
    logic [7:0] expQ[$];

    // Divider model: sclk_in toggles every halfP clk_in cycles while sclkRun is set.
    int   halfP   = 2;
    logic sclkRun = 1'b1;
    int   divCnt  = 0;
    initial sclk_in = 1'b0;
    always @(posedge clk_in) begin
        if (!sclkRun) begin
            sclk_in <= 1'b0;
            divCnt  <= 0;
        end else if (divCnt >= halfP - 1) begin
            sclk_in <= ~sclk_in;
            divCnt  <= 0;
        end else begin
            divCnt <= divCnt + 1;
        end
    end

    // Chip model: MSB-first shift on sr_clk rise, parallel latch on sr_load rise.
    int         doutMode    = 0;
    logic       chipPreload = 1'b0;
    logic [7:0] chipInit    = 8'h00;
    logic [7:0] chipReg;
    logic [7:0] chipLatch;
    always @(posedge sr_clk or posedge chipPreload) begin
        if (chipPreload) chipReg <= chipInit;
        else             chipReg <= {chipReg[6:0], sr_din};
    end
    always @(posedge sr_load) chipLatch <= chipReg;

    assign sr_dout = (doutMode == 1) ? chipReg[7] : (doutMode == 0) ? sr_din : 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        @(negedge clk_in);
        bus.wr_data = data;
        bus.start   = 1'b1;
        @(negedge clk_in);
        bus.start   = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles);
        int base;
        base = doneCount;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk_in);
            #1;
            if (doneCount != base) break;
        end
        checkOutput("done_seen", doneCount - base, 1);
    endtask

    task automatic waitRises(input int n, input int maxCycles);
        int base;
        base = riseCount;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk_in);
            #1;
            if (riseCount - base >= n) break;
        end
        checkOutput("rises_reached", riseCount - base, n);
    endtask

    function automatic logic [12:0] allOutputs();
        return {bus.busy, bus.done, sr_clk, sr_din, sr_load, bus.rd_data};
    endfunction

    // Monitor: tracks serial activity and scores every done pulse against the queue.
    initial begin
        logic prevSrClk;
        logic [7:0] exp;
        prevSrClk = 1'b0;
        forever begin
            @(negedge clk_in);
            if (sr_clk && !prevSrClk) begin
                riseCount++;
                dinLog = {dinLog[6:0], sr_din};
            end
            prevSrClk = sr_clk;
            if (sr_load) loadCycles++;
            if (bus.done) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'(bus.rd_data), 32'hFFFF_FFFF);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("rd_data", 32'(bus.rd_data), 32'(exp));
                    checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int riseBase, loadBase, doneBase, bad;
        bus.start   = 1'b0;
        bus.wr_data = '0;

        // Reset values
        #22;
        checkOutput("reset_outputs", 32'(allOutputs()), 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (allOutputs() !== 13'd0) bad++;
        end
        checkOutput("idle_100_cycles", bad, 0);

        // Loopback write 0xA5, P=4
        doutMode = 0;
        riseBase = riseCount; loadBase = loadCycles; doneBase = doneCount;
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5);
        checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
        waitDone(200);
        repeat (20) @(negedge clk_in);
        #1;
        checkOutput("din_sequence", 32'(dinLog), 32'hA5);
        checkOutput("sr_clk_rises", riseCount - riseBase, 8);
        checkOutput("sr_load_cycles", loadCycles - loadBase, 4);
        checkOutput("done_pulses", doneCount - doneBase, 1);

        // Chip-model readback
        doutMode = 1;
        chipInit = 8'h3C;
        @(negedge clk_in); chipPreload = 1'b1;
        @(negedge clk_in); chipPreload = 1'b0;
        expQ.push_back(8'h3C);
        applyStimulus(8'hFF);
        waitDone(200);
        checkOutput("chip_latched", 32'(chipLatch), 32'hFF);

        // Start while busy is ignored
        doutMode = 0;
        doneBase = doneCount;
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5);
        waitRises(3, 100);
        applyStimulus(8'h11);
        waitDone(200);
        repeat (60) @(negedge clk_in);
        #1;
        checkOutput("single_done", doneCount - doneBase, 1);
        checkOutput("queue_empty", expQ.size(), 0);

        // Reset mid-shift
        applyStimulus(8'hF0);
        waitRises(3, 100);
        rst_n = 1'b0;
        #1;
        checkOutput("midshift_reset", 32'(allOutputs()), 32'd0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        expQ.push_back(8'h5A);
        applyStimulus(8'h5A);
        waitDone(200);

        // Dead clock: engine waits forever with no serial clock activity
        @(negedge clk_in);
        sclkRun = 1'b0;
        repeat (5) @(negedge clk_in);
        riseBase = riseCount;
        applyStimulus(8'h77);
        checkOutput("dead_busy", 32'(bus.busy), 32'd1);
        repeat (1000) @(negedge clk_in);
        #1;
        checkOutput("dead_no_rises", riseCount - riseBase, 0);
        checkOutput("dead_still_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;

        // Fastest clock, P=2
        halfP   = 1;
        sclkRun = 1'b1;
        riseBase = riseCount;
        expQ.push_back(8'hC3);
        applyStimulus(8'hC3);
        waitDone(200);
        checkOutput("fast_rises", riseCount - riseBase, 8);

        repeat (5) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/shiftreg_rw_engine.md
# shiftreg_rw_engine

Serial shift-register write/readback engine for the TMIIa test firmware. It consumes the divided serial clock produced by the clock divider stage and turns it into a gated `sr_clk`, MSB-first `sr_din`, and an `sr_load` strobe for the chip's configuration shift register. It captures the chip's `sr_dout` into a parallel readback word. Everything runs in the `clk_in` domain; the divided clock is synchronized and edge-detected, never used as a clock.

## Interface
- `WIDTH`, default 32: shift-register length in bits (≥2).
- `CNT_WIDTH`, default `$clog2(WIDTH+1)`: width of the bit counter.

Ports (clock and reset first):
- `clk_in`  in  1: system clock, the same clock that feeds the divider.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sclk_in`  in  1: divided clock from the divider stage. Period must be ≥2 `clk_in` cycles, so divider `div` ≥1.
- `start`  in  1: start request; sampled in IDLE only.
- `wr_data`  in  WIDTH: word to shift out, MSB first; latched on accept.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle completion pulse.
- `rd_data`  out  WIDTH: readback word; updated only when `done` fires.
- `sr_clk`  out  1: gated serial clock to the chip.
- `sr_din`  out  1: serial data to the chip.
- `sr_load`  out  1: parallel-load strobe to the chip.
- `sr_dout`  in  1: serial data from the chip.

## Operation
- **Edge detection.** `sclk_in` passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- **State machine:** IDLE, ARM, SHIFT, LOAD.
  - **IDLE.** All serial outputs are 0.
    - `start`=1: `shreg`<=`wr_data`, `cnt`<=WIDTH, `busy`<=1, go to ARM.
  - **ARM.** Ignores rise events.
    - fall: `sr_din`<=`shreg[WIDTH-1]`, go to SHIFT.
  - **SHIFT.**
    - rise: `sr_clk`<=1, `shreg`<={`shreg[WIDTH-2:0]`, `sr_dout`}, `cnt`<=`cnt`-1.
    - fall with `cnt`≠0: `sr_clk`<=0, `sr_din`<=`shreg[WIDTH-1]`.
    - fall with `cnt`==0: `sr_clk`<=0, `sr_din`<=0, `sr_load`<=1, go to LOAD.
  - **LOAD.**
    - fall: `sr_load`<=0, `rd_data`<=`shreg`, `done`<=1, `busy`<=0, go to IDLE.
- **Bit order.**
  - The first bit received ends in `rd_data[WIDTH-1]`.
  - `sr_dout` is sampled on the same `clk_in` edge that raises `sr_clk`, so it is the value present before the chip sees that edge.
- **`start` handling.** `start` is ignored while `busy`=1. No queuing.
- **Dead clock.** If `sclk_in` stops, the FSM waits indefinitely. Recovery is by reset only.
- **Reset (async, `rst_n`=0).** Takes effect immediately, including mid-operation:
  - `busy`, `done`, `sr_clk`, `sr_din`, `sr_load`, `rd_data`, `shreg`, `cnt`, and the synchronizer flops all go to 0.
  - State goes to IDLE.

## Timing
- All outputs are registered.
- `sr_clk` follows `sclk_in` with a 3-`clk_in`-cycle lag (2 synchronizer + 1 output), for exactly WIDTH full pulses.
- `sr_din` changes only on falling `sr_clk`. It is stable for ½P before each rise and ½P after it (P = `sclk_in` period in `clk_in` cycles).
- `busy` rises 1 cycle after `start` is accepted.
- `sr_load` is high for exactly P cycles, fall to fall.
- `done` is high for 1 cycle, coincident with `busy` falling and `rd_data` updating.
- Total time from accept to `done` is (WIDTH+1)·P plus up to P (alignment to the first fall) plus 3 cycles.
- A new `start` is accepted no earlier than the cycle after `done`.

## Test plan
- **Reset values.** Assert `rst_n`=0 at an arbitrary point → every output is 0. Deassert, with no `start` → outputs stay 0 for 100 cycles.
- **Loopback write.** WIDTH=8, P=4 (div=2), `sr_dout` tied to `sr_din`, `wr_data`=0xA5 → `sr_din` bit sequence 1,0,1,0,0,1,0,1; exactly 8 `sr_clk` rises; `sr_load` high for 4 cycles; `done` pulses once; `rd_data`=0xA5.
- **Chip-model readback.** Use an 8-bit chip model preloaded with 0x3C that shifts out MSB-first on `sr_clk` rise. `wr_data`=0xFF → `rd_data`=0x3C, and the model holds 0xFF after `sr_load`.
- **Start while busy.** Pulse `start` with `wr_data`=0x11 during SHIFT of a 0xA5 transfer → the transfer completes with 0xA5; only one `done` pulse.
- **Reset mid-shift.** Assert `rst_n` after 3 `sr_clk` rises → all outputs 0 immediately. Then a fresh `start` with 0x5A → loopback `rd_data`=0x5A.
- **Dead or fast clock.** With `sclk_in` held at 0, `start` → `busy`=1 and no `sr_clk` edges for 1000 cycles. With P=2 (div=1), loopback 0xC3 → `rd_data`=0xC3.
